lsu: RTL and testbench

Load/store initiator sitting between the npc core's memory stage and the `pmem` responder. Accepts one byte/half/word/double load or store per transaction from the core and issues 8-byte-aligned read/write beats, with byte masks, over a valid/ready request channel. Responses return on a response pulse. Misaligned accesses that cross an 8-byte boundary are split into two beats. Load data is realigned and zero- or sign-extended before it returns to the core.

---
 rtl/lsu.sv | 195 +++++++++++++++++++
 tb/tb_lsu.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store initiator: turns one core byte/half/word/double access into one or two
// 8-byte-aligned memory beats, and realigns and extends load data on the way back.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StReq0,
        StWait0,
        StReq1,
        StWait1,
        StResp
    } state_e;

    state_e        state_q, state_d;
    logic [60:0]   base_q, base_d;
    logic [2:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          wen_q, wen_d;
    logic          split_q, split_d;
    logic [127:0]  wdata_sh_q, wdata_sh_d;
    logic [15:0]   wmask_sh_q, wmask_sh_d;
    logic [63:0]   lo_q, lo_d;
    logic [63:0]   hi_q, hi_d;

    logic [3:0]    req_bytes;
    logic          req_split;
    logic [7:0]    req_mask;
    logic [63:0]   hi_eff;
    logic [63:0]   ld_raw;
    logic [63:0]   ld_ext;

    assign req_ready = (state_q == StIdle) && !rst;

    assign req_bytes = 4'd1 << req_size;
    assign req_split = ({1'b0, req_addr[2:0]} + req_bytes) > 4'd8;

    always_comb begin
        req_mask = 8'h00;
        unique case (req_size)
            2'd0: req_mask = 8'h01;
            2'd1: req_mask = 8'h03;
            2'd2: req_mask = 8'h0F;
            2'd3: req_mask = 8'hFF;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
        wen_d      = wen_q;
        split_d    = split_q;
        wdata_sh_d = wdata_sh_q;
        wmask_sh_d = wmask_sh_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    base_d     = req_addr[63:3];
                    off_d      = req_addr[2:0];
                    size_d     = req_size;
                    uns_d      = req_unsigned;
                    wen_d      = req_wen;
                    split_d    = req_split;
                    // 128-bit shifted views: low half feeds beat 0, high half beat 1
                    wdata_sh_d = {64'd0, req_wdata} << {req_addr[2:0], 3'b000};
                    wmask_sh_d = req_wen ? ({8'd0, req_mask} << req_addr[2:0]) : 16'd0;
                    lo_d       = '0;
                    hi_d       = '0;
                    state_d    = StReq0;
                end
            end
            StReq0: begin
                if (mem_ready) state_d = StWait0;
            end
            StWait0: begin
                if (mem_rvalid) begin
                    lo_d    = mem_rdata;
                    state_d = split_q ? StReq1 : StResp;
                end
            end
            StReq1: begin
                if (mem_ready) state_d = StWait1;
            end
            StWait1: begin
                if (mem_rvalid) begin
                    hi_d    = mem_rdata;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            base_q     <= '0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            wen_q      <= 1'b0;
            split_q    <= 1'b0;
            wdata_sh_q <= '0;
            wmask_sh_q <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            wen_q      <= wen_d;
            split_q    <= split_d;
            wdata_sh_q <= wdata_sh_d;
            wmask_sh_q <= wmask_sh_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
        end
    end

    // Memory side is decoded from state so reset clears it without waiting for a clock.
    always_comb begin
        mem_valid = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        case (state_q)
            StReq0: begin
                mem_valid = 1'b1;
                mem_wen   = wen_q;
                mem_addr  = {base_q, 3'b000};
                mem_wdata = wdata_sh_q[63:0];
                mem_wmask = wmask_sh_q[7:0];
            end
            StReq1: begin
                mem_valid = 1'b1;
                mem_wen   = wen_q;
                mem_addr  = {base_q + 61'd1, 3'b000};
                mem_wdata = wdata_sh_q[127:64];
                mem_wmask = wmask_sh_q[15:8];
            end
            default: begin
            end
        endcase
    end

    assign hi_eff = split_q ? hi_q : 64'd0;
    assign ld_raw = 64'({hi_eff, lo_q} >> {off_q, 3'b000});

    always_comb begin
        ld_ext = '0;
        unique case (size_q)
            2'd0: ld_ext = uns_q ? {56'd0, ld_raw[7:0]}  : {{56{ld_raw[7]}}, ld_raw[7:0]};
            2'd1: ld_ext = uns_q ? {48'd0, ld_raw[15:0]} : {{48{ld_raw[15]}}, ld_raw[15:0]};
            2'd2: ld_ext = uns_q ? {32'd0, ld_raw[31:0]} : {{32{ld_raw[31]}}, ld_raw[31:0]};
            2'd3: ld_ext = ld_raw;
        endcase
    end

    assign resp_valid = (state_q == StResp);
    assign resp_rdata = (resp_valid && !wen_q) ? ld_ext : 64'd0;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: table of accesses with a beat-level responder model and a response
// scoreboard, plus hand sequences for address wrap and mid-transaction reset.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    always #5 clk = ~clk;

    lsu dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        logic        drop;
    } beat_t;

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] wdata;
        int          nbeats;
        beat_t       b0;
        beat_t       b1;
        logic [63:0] exp_rdata;
        int          stall;
        logic        spur;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        int          lat;
        int          acc_cyc;
        int          idx;
    } exp_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    beat_t beat_q[$];
    exp_t  sb_q[$];
    int    stall_cnt = 0;
    logic  spur_en = 1'b0;
    logic  force_rvalid = 1'b0;
    logic  hs_next = 1'b0;
    logic  hs_drop = 1'b0;
    logic [63:0] hs_data = 64'd0;
    int    beats_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic beat_t mkb(logic [63:0] addr, logic wen, logic [63:0] wdata,
                                  logic [7:0] wmask, logic [63:0] rdata, logic drop);
        beat_t b;
        b.addr = addr; b.wen = wen; b.wdata = wdata; b.wmask = wmask;
        b.rdata = rdata; b.drop = drop;
        return b;
    endfunction

    function automatic vec_t mkv(logic wen, logic [63:0] addr, logic [1:0] size, logic uns,
                                 logic [63:0] wdata, int nb, beat_t b0, beat_t b1,
                                 logic [63:0] exp_rdata, int stall, logic spur);
        vec_t v;
        v.wen = wen; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.nbeats = nb; v.b0 = b0; v.b1 = b1; v.exp_rdata = exp_rdata;
        v.stall = stall; v.spur = spur;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Response scoreboard and memory responder, both sampled mid-cycle.
    always @(negedge clk) begin : mon_resp
        exp_t e;
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid rdata %h expected none", resp_rdata);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("v%0d_resp_rdata", e.idx), resp_rdata, e.rdata);
                chk($sformatf("v%0d_resp_latency", e.idx), 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
            end
        end

        if (hs_next && !hs_drop) begin
            mem_rvalid = 1'b1;
            mem_rdata  = hs_data;
        end else if (force_rvalid) begin
            mem_rvalid   = 1'b1;
            mem_rdata    = 64'h5A5A_5A5A_5A5A_5A5A;
            force_rvalid = 1'b0;
        end else if (spur_en && mem_valid && stall_cnt > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 64'd0;
        end
        hs_next   = 1'b0;
        mem_ready = 1'b0;
        if (mem_valid) begin
            if (beat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got mem_addr %h expected no beat", mem_addr);
            end else begin
                chk("beat_addr", mem_addr, beat_q[0].addr);
                chk("beat_wen", 64'(mem_wen), 64'(beat_q[0].wen));
                chk("beat_wdata", mem_wdata, beat_q[0].wdata);
                chk("beat_wmask", 64'(mem_wmask), 64'(beat_q[0].wmask));
                if (stall_cnt > 0) begin
                    stall_cnt--;
                end else begin
                    mem_ready = 1'b1;
                    hs_next   = 1'b1;
                    hs_data   = beat_q[0].rdata;
                    hs_drop   = beat_q[0].drop;
                    void'(beat_q.pop_front());
                    beats_acc++;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic do_txn(input vec_t v, input int idx, input bit expect_resp);
        int   n;
        exp_t e;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL v%0d_req_ready_timeout: got 0 expected 1", idx);
            return;
        end
        beat_q.push_back(v.b0);
        if (v.nbeats == 2) beat_q.push_back(v.b1);
        stall_cnt    = v.stall;
        spur_en      = v.spur;
        req_valid    = 1'b1;
        req_wen      = v.wen;
        req_addr     = v.addr;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_wdata    = v.wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid    = 1'b0;
        req_wen      = 1'b0;
        req_addr     = 64'd0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 64'd0;
        e.rdata   = v.exp_rdata;
        e.lat     = ((v.nbeats == 2) ? 5 : 3) + v.stall;
        e.acc_cyc = cyc;
        e.idx     = idx;
        if (expect_resp) sb_q.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[13];
        vec_t  v;
        beat_t nb;
        int    n;
        int    b;

        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 64'd0;

        nb = mkb(64'd0, 1'b0, 64'd0, 8'h00, 64'd0, 1'b0);
        tbl[0]  = mkv(0, 64'h8000_0008, 3, 0, 0, 1,
                      mkb(64'h8000_0008, 0, 0, 8'h00, 64'h1122_3344_5566_7788, 0), nb,
                      64'h1122_3344_5566_7788, 0, 0);
        tbl[1]  = mkv(0, 64'h8000_0003, 0, 0, 0, 1,
                      mkb(64'h8000_0000, 0, 0, 8'h00, 64'h0000_0000_8000_0000, 0), nb,
                      64'hFFFF_FFFF_FFFF_FF80, 0, 0);
        tbl[2]  = mkv(0, 64'h8000_0003, 0, 1, 0, 1,
                      mkb(64'h8000_0000, 0, 0, 8'h00, 64'h0000_0000_8000_0000, 0), nb,
                      64'h0000_0000_0000_0080, 0, 0);
        tbl[3]  = mkv(0, 64'h8000_0006, 2, 0, 0, 2,
                      mkb(64'h8000_0000, 0, 0, 8'h00, 64'hBBAA_0000_0000_0000, 0),
                      mkb(64'h8000_0008, 0, 0, 8'h00, 64'h0000_0000_0000_DDCC, 0),
                      64'hFFFF_FFFF_DDCC_BBAA, 0, 0);
        tbl[4]  = mkv(1, 64'h8000_0005, 1, 0, 64'h1234, 1,
                      mkb(64'h8000_0000, 1, 64'h0012_3400_0000_0000, 8'h60,
                          64'hFFFF_FFFF_FFFF_FFFF, 0), nb, 64'd0, 0, 0);
        tbl[5]  = mkv(1, 64'h8000_0004, 3, 0, 64'h0102_0304_0506_0708, 2,
                      mkb(64'h8000_0000, 1, 64'h0506_0708_0000_0000, 8'hF0, 64'h1111, 0),
                      mkb(64'h8000_0008, 1, 64'h0000_0000_0102_0304, 8'h0F, 64'h2222, 0),
                      64'd0, 0, 0);
        tbl[6]  = mkv(0, 64'h8000_0010, 3, 0, 0, 1,
                      mkb(64'h8000_0010, 0, 0, 8'h00, 64'hCAFE_F00D_1234_5678, 0), nb,
                      64'hCAFE_F00D_1234_5678, 4, 1);
        tbl[7]  = mkv(0, 64'h8000_0007, 1, 0, 0, 2,
                      mkb(64'h8000_0000, 0, 0, 8'h00, 64'hAB00_0000_0000_0000, 0),
                      mkb(64'h8000_0008, 0, 0, 8'h00, 64'h0000_0000_0000_00F1, 0),
                      64'hFFFF_FFFF_FFFF_F1AB, 0, 0);
        tbl[8]  = mkv(0, 64'h8000_000C, 2, 1, 0, 1,
                      mkb(64'h8000_0008, 0, 0, 8'h00, 64'h89AB_CDEF_0000_0000, 0), nb,
                      64'h0000_0000_89AB_CDEF, 0, 0);
        tbl[9]  = mkv(1, 64'h8000_0007, 0, 0, 64'hAA, 1,
                      mkb(64'h8000_0000, 1, 64'hAA00_0000_0000_0000, 8'h80, 64'd0, 0), nb,
                      64'd0, 0, 0);
        tbl[10] = mkv(1, 64'h8000_0006, 2, 0, 64'hDEAD_BEEF, 2,
                      mkb(64'h8000_0000, 1, 64'hBEEF_0000_0000_0000, 8'hC0, 64'd0, 0),
                      mkb(64'h8000_0008, 1, 64'h0000_0000_0000_DEAD, 8'h03, 64'd0, 0),
                      64'd0, 0, 0);
        tbl[11] = mkv(0, 64'h8000_0000, 2, 0, 0, 1,
                      mkb(64'h8000_0000, 0, 0, 8'h00, 64'hFFFF_FFFF_7FFF_FFFF, 0), nb,
                      64'h0000_0000_7FFF_FFFF, 0, 0);
        tbl[12] = mkv(0, 64'h8000_0002, 1, 1, 0, 1,
                      mkb(64'h8000_0000, 0, 0, 8'h00, 64'h1234_5678_F00D_9999, 0), nb,
                      64'h0000_0000_0000_F00D, 0, 0);

        repeat (2) @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_mem_valid", 64'(mem_valid), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_mem_addr", mem_addr, 64'd0);
        chk("reset_resp_rdata", resp_rdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 13; i++) do_txn(tbl[i], i, 1'b1);

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("table_drain", 64'(sb_q.size()), 64'd0);

        // Wrapping split load, then reset while waiting on the second beat.
        v = mkv(0, 64'hFFFF_FFFF_FFFF_FFFC, 3, 0, 0, 2,
                mkb(64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 8'h00, 64'h0123_4567_89AB_CDEF, 0),
                mkb(64'h0000_0000_0000_0000, 0, 0, 8'h00, 64'd0, 1),
                64'd0, 0, 0);
        b = beats_acc;
        do_txn(v, 99, 1'b0);
        n = 0;
        while (beats_acc < b + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_beats_issued", 64'(beats_acc - b), 64'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_mem_valid", 64'(mem_valid), 64'd0);
        chk("midrst_mem_wen", 64'(mem_wen), 64'd0);
        chk("midrst_mem_addr", mem_addr, 64'd0);
        chk("midrst_mem_wdata", mem_wdata, 64'd0);
        chk("midrst_mem_wmask", 64'(mem_wmask), 64'd0);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_resp_rdata", resp_rdata, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rst_req_ready", 64'(req_ready), 64'd1);
        force_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("late_rvalid_idle_%0d", k), 64'(req_ready), 64'd1);
            chk($sformatf("late_rvalid_novalid_%0d", k), 64'(mem_valid), 64'd0);
        end

        do_txn(tbl[0], 100, 1'b1);
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("final_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("final_beats_empty", 64'(beat_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
